voice_mix_sequencer: RTL and testbench

- Upstream/downstream companion of the shared serial multiplier in the synth datapath.
- Latches one sample and one gain per voice on start, then issues one multiply per enabled voice through the external multiplier handshake (operands, trigger, ready, done).
- Accumulates the low-word products into a signed mix and outputs the final mix with a one-cycle done pulse.
- Owns all multiplier sequencing, so voice logic never drives the multiplier directly.

---
 rtl/voice_mix_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_voice_mix_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_mix_sequencer.sv
// voice_mix_sequencer
//   Latches one sample and one gain per voice on start. For each enabled voice
//   it runs one multiply on the shared external serial multiplier, sums the
//   signed low-word products and presents the mix with a one-cycle done pulse.
//   It is the only block that drives the multiplier, so voice logic never
//   touches it directly.
//
// Ports
//   ctl_clk, reset        clock (posedge) and synchronous active-high reset
//   start                 one-cycle mix request, accepted only while idle
//   voice_en              per-voice enable mask, latched on accepted start
//   voice_samples/gains   flattened per-voice operands, voice i at [i*C_WIDTH +: C_WIDTH]
//   mul_a, mul_b          multiplier operands (sample, gain)
//   mul_trigger           multiplier start, one cycle, registered
//   mul_ready, mul_done   multiplier handshake inputs
//   mul_y                 multiplier result (low word of product)
//   busy                  high from accepted start until done or error
//   mix_out, done         final mix and its one-cycle update pulse
//   error                 one-cycle pulse when a multiplier wait times out
//
// Build option
//   VOICE_MIX_SATURATE_EN  defined: the final mix clamps to the signed C_WIDTH
//                          range; undefined: the final mix wraps (low bits).
//
// state   | meaning
// IDLE    | waiting for start
// SCAN    | look at voice idx: skip it, multiply it, or finish
// W_READY | operands presented, waiting for mul_ready
// ISSUE   | mul_trigger high for this single cycle
// W_DONE  | waiting for mul_done, product captured on it
// ACC     | add sign-extended product into the accumulator
// FINISH  | publish mix_out, pulse done

module voice_mix_sequencer #(
    parameter int C_WIDTH     = 32,
    parameter int C_VOICES    = 8,
    parameter int C_IDX_WIDTH = 3,
    parameter int C_TIMEOUT   = 255
) (
    input  logic                          ctl_clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [C_VOICES-1:0]           voice_en,
    input  logic [C_VOICES*C_WIDTH-1:0]   voice_samples,
    input  logic [C_VOICES*C_WIDTH-1:0]   voice_gains,
    output logic [C_WIDTH-1:0]            mul_a,
    output logic [C_WIDTH-1:0]            mul_b,
    output logic                          mul_trigger,
    input  logic                          mul_ready,
    input  logic                          mul_done,
    input  logic [C_WIDTH-1:0]            mul_y,
    output logic                          busy,
    output logic [C_WIDTH-1:0]            mix_out,
    output logic                          done,
    output logic                          error
);

    // Index needs one extra bit so it can hold C_VOICES (the "all scanned" value).
    localparam int IW = C_IDX_WIDTH + 1;
    localparam int AW = C_WIDTH + C_IDX_WIDTH;
    localparam int TW = $clog2(C_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_W_READY, S_ISSUE, S_W_DONE, S_ACC, S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [C_WIDTH-1:0]   prod_q, prod_d;
    logic [TW-1:0]        wd_q, wd_d;
    logic [C_WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic                 trig_q, trig_d;
    logic                 busy_q, busy_d;
    logic [C_WIDTH-1:0]   mix_q, mix_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [C_VOICES-1:0]  en_q;
    logic [C_WIDTH-1:0]   samp_q [C_VOICES];
    logic [C_WIDTH-1:0]   gain_q [C_VOICES];

    logic [C_IDX_WIDTH-1:0] idx_lo;
    logic                   at_end;
    logic                   en_cur;
    logic                   wd_expired;
    logic [C_WIDTH-1:0]     mix_red;

    assign idx_lo     = idx_q[C_IDX_WIDTH-1:0];
    assign at_end     = (idx_q == IW'(C_VOICES));
    assign en_cur     = en_q[idx_lo];
    // Abort on the last of C_TIMEOUT wait cycles; the counter is 0 in the first one.
    assign wd_expired = (wd_q == TW'(C_TIMEOUT - 1));

    // Operand capture has no reset: it is only consumed after an accepted start.
    always_ff @(posedge ctl_clk) begin
        if (state_q == S_IDLE && start) begin
            en_q <= voice_en;
            for (int i = 0; i < C_VOICES; i++) begin
                samp_q[i] <= voice_samples[i*C_WIDTH +: C_WIDTH];
                gain_q[i] <= voice_gains[i*C_WIDTH +: C_WIDTH];
            end
        end
    end

    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            wd_q    <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            mix_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            wd_q    <= wd_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            mix_q   <= mix_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_SCAN;
            S_SCAN: begin
                if (at_end)      state_d = S_FINISH;
                else if (en_cur) state_d = S_W_READY;
            end
            S_W_READY: begin
                if (mul_ready)       state_d = S_ISSUE;
                else if (wd_expired) state_d = S_IDLE;
            end
            S_ISSUE:   state_d = S_W_DONE;
            S_W_DONE: begin
                if (mul_done)        state_d = S_ACC;
                else if (wd_expired) state_d = S_IDLE;
            end
            S_ACC:     state_d = S_SCAN;
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mix_red = acc_q[C_WIDTH-1:0];
`ifdef VOICE_MIX_SATURATE_EN
        // Fits when every bit from the C_WIDTH sign position upward agrees.
        if (!((&acc_q[AW-1:C_WIDTH-1]) || !(|acc_q[AW-1:C_WIDTH-1]))) begin
            if (acc_q[AW-1]) mix_red = {1'b1, {(C_WIDTH-1){1'b0}}};
            else             mix_red = {1'b0, {(C_WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        idx_d   = idx_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        busy_d  = busy_q;
        mix_d   = mix_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        // Registered trigger follows the next state, so it is high exactly in ISSUE.
        trig_d  = (state_d == S_ISSUE);

        if (state_d != state_q)
            wd_d = '0;
        else if (state_q == S_W_READY || state_q == S_W_DONE)
            wd_d = wd_q + 1'b1;
        else
            wd_d = wd_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d  = '0;
                    acc_d  = '0;
                    busy_d = 1'b1;
                end
            end
            S_SCAN: begin
                if (!at_end && !en_cur) idx_d = idx_q + 1'b1;
                if (state_d == S_W_READY) begin
                    mul_a_d = samp_q[idx_lo];
                    mul_b_d = gain_q[idx_lo];
                end
            end
            S_W_READY: begin
                if (state_d == S_IDLE) begin
                    err_d  = 1'b1;
                    busy_d = 1'b0;
                end
            end
            S_W_DONE: begin
                if (mul_done) begin
                    prod_d = mul_y;
                end else if (state_d == S_IDLE) begin
                    err_d  = 1'b1;
                    busy_d = 1'b0;
                end
            end
            S_ACC: begin
                acc_d = acc_q + {{C_IDX_WIDTH{prod_q[C_WIDTH-1]}}, prod_q};
                idx_d = idx_q + 1'b1;
            end
            S_FINISH: begin
                mix_d  = mix_red;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_trigger = trig_q;
    assign busy        = busy_q;
    assign mix_out     = mix_q;
    assign done        = done_q;
    assign error       = err_q;

endmodule

// File: tb/tb_voice_mix_sequencer.sv
module tb_voice_mix_sequencer;

    logic         ctl_clk = 1'b0;
    logic         reset;
    logic         start;
    logic [7:0]   voice_en;
    logic [255:0] voice_samples;
    logic [255:0] voice_gains;
    logic [31:0]  mul_a, mul_b;
    logic         mul_trigger;
    logic         mul_ready;
    logic         mul_done;
    logic [31:0]  mul_y;
    logic         busy;
    logic [31:0]  mix_out;
    logic         done;
    logic         error;

    voice_mix_sequencer dut (
        .ctl_clk       (ctl_clk),
        .reset         (reset),
        .start         (start),
        .voice_en      (voice_en),
        .voice_samples (voice_samples),
        .voice_gains   (voice_gains),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_trigger   (mul_trigger),
        .mul_ready     (mul_ready),
        .mul_done      (mul_done),
        .mul_y         (mul_y),
        .busy          (busy),
        .mix_out       (mix_out),
        .done          (done),
        .error         (error)
    );

    always #5 ctl_clk = ~ctl_clk;

    typedef struct {
        bit          is_err;
        logic [31:0] mix;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] op_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          ready_en = 1'b1;

`ifdef VOICE_MIX_SATURATE_EN
    localparam logic [31:0] OVF_MIX = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_MIX = 32'hFFFF_FFFE;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] put2(input int i0, input logic [31:0] v0,
                                          input int i1, input logic [31:0] v1);
        logic [255:0] r;
        r = '0;
        r[i0*32 +: 32] = v0;
        r[i1*32 +: 32] = v1;
        return r;
    endfunction

    // Behavioural serial multiplier, about 34 cycles from trigger to done.
    initial begin
        logic [31:0] ma, mb;
        forever begin
            @(negedge ctl_clk);
            if (mul_trigger) begin
                ma = mul_a;
                mb = mul_b;
                mul_ready = 1'b0;
                repeat (34) @(negedge ctl_clk);
                mul_y    = ma * mb;
                mul_done = 1'b1;
                @(negedge ctl_clk);
                mul_done  = 1'b0;
                mul_ready = ready_en;
            end
        end
    end

    // Monitor: operand check on every trigger, result check on every done/error.
    initial begin
        logic [63:0] op;
        exp_t        e;
        forever begin
            @(negedge ctl_clk);
            if (!reset) begin
                if (mul_trigger) begin
                    if (op_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_trigger: got a=%h b=%h expected no trigger", mul_a, mul_b);
                    end else begin
                        op = op_q.pop_front();
                        check("mul_a", mul_a, op[63:32]);
                        check("mul_b", mul_b, op[31:0]);
                    end
                end
                if (done || error) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_response: got done=%b error=%b expected none", done, error);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_is_error", {31'b0, error}, {31'b0, e.is_err});
                        check("resp_done", {31'b0, done}, {31'b0, ~e.is_err});
                        check("mix_out", mix_out, e.mix);
                        check("busy_at_resp", {31'b0, busy}, 32'd0);
                    end
                end
            end
        end
    end

    task automatic push_exp(input bit is_err, input logic [31:0] mix);
        exp_t e;
        e.is_err = is_err;
        e.mix    = mix;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input logic [7:0] en, input logic [255:0] s, input logic [255:0] g);
        voice_en      = en;
        voice_samples = s;
        voice_gains   = g;
        start         = 1'b1;
        @(negedge ctl_clk);
        start         = 1'b0;
    endtask

    // Cycles counted from the edge that accepted start; -1 skips the latency check.
    task automatic wait_resp(input string name, input int limit, input int exp_cycles);
        int cycles;
        bit got;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < limit) begin
            @(negedge ctl_clk);
            cycles++;
            if (done || error) got = 1'b1;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got no response in %0d cycles expected one", name, limit);
        end else if (exp_cycles >= 0) begin
            check({name, "_latency"}, 32'(cycles), 32'(exp_cycles));
        end
        repeat (3) @(negedge ctl_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mul_a"},   mul_a, 32'd0);
        check({tag, "_mul_b"},   mul_b, 32'd0);
        check({tag, "_trigger"}, {31'b0, mul_trigger}, 32'd0);
        check({tag, "_busy"},    {31'b0, busy}, 32'd0);
        check({tag, "_mix_out"}, mix_out, 32'd0);
        check({tag, "_done"},    {31'b0, done}, 32'd0);
        check({tag, "_error"},   {31'b0, error}, 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; voice_en = '0;
        voice_samples = '0; voice_gains = '0;
        mul_ready = 1'b1; mul_done = 1'b0; mul_y = '0;
        repeat (3) @(negedge ctl_clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge ctl_clk);

        // Basic mix: 3*4 + 5*6 = 42
        op_q.push_back({32'd3, 32'd4});
        op_q.push_back({32'd5, 32'd6});
        push_exp(1'b0, 32'd42);
        pulse_start(8'h05, put2(0, 32'd3, 2, 32'd5), put2(0, 32'd4, 2, 32'd6));
        wait_resp("basic", 300, -1);
        check("basic_busy_after", {31'b0, busy}, 32'd0);

        // Signed mix (-2*3 + 10*1 = 4) with an ignored start while busy
        op_q.push_back({32'hFFFF_FFFE, 32'd3});
        op_q.push_back({32'd10, 32'd1});
        push_exp(1'b0, 32'd4);
        pulse_start(8'h03, put2(0, 32'hFFFF_FFFE, 1, 32'd10), put2(0, 32'd3, 1, 32'd1));
        repeat (3) @(negedge ctl_clk);
        pulse_start(8'hFF, {8{32'h1111_1111}}, {8{32'h2222_2222}});
        wait_resp("signed", 300, -1);

        // Overflow: two voices of 0x7FFF_FFFF * 1
        op_q.push_back({32'h7FFF_FFFF, 32'd1});
        op_q.push_back({32'h7FFF_FFFF, 32'd1});
        push_exp(1'b0, OVF_MIX);
        pulse_start(8'h03, put2(0, 32'h7FFF_FFFF, 1, 32'h7FFF_FFFF), put2(0, 32'd1, 1, 32'd1));
        wait_resp("overflow", 300, -1);

        // Timeout in W_READY: error after 255 waiting cycles, mix_out untouched
        ready_en  = 1'b0;
        mul_ready = 1'b0;
        push_exp(1'b1, OVF_MIX);
        pulse_start(8'h01, put2(0, 32'd7, 1, 32'd0), put2(0, 32'd7, 1, 32'd0));
        wait_resp("timeout", 400, 256);
        ready_en  = 1'b1;
        mul_ready = 1'b1;

        // Empty mask: no multiply, done 10 cycles after start, mix 0
        push_exp(1'b0, 32'd0);
        pulse_start(8'h00, put2(0, 32'd9, 1, 32'd9), put2(0, 32'd9, 1, 32'd9));
        wait_resp("empty", 50, 10);

        // Reset while waiting for the multiplier result
        op_q.push_back({32'd9, 32'd9});
        pulse_start(8'h01, put2(0, 32'd9, 1, 32'd0), put2(0, 32'd9, 1, 32'd0));
        n = 0;
        while (!mul_trigger && n < 20) begin
            @(negedge ctl_clk);
            n++;
        end
        check("reset_run_trigger_seen", {31'b0, mul_trigger}, 32'd1);
        repeat (5) @(negedge ctl_clk);
        reset = 1'b1;
        @(posedge ctl_clk);
        #1;
        check_all_zero("midrun_reset");
        @(negedge ctl_clk);
        reset = 1'b0;
        repeat (45) @(negedge ctl_clk);

        // Fresh run after reset: 2*(-1) + 100*3 = 298
        op_q.push_back({32'd2, 32'hFFFF_FFFF});
        op_q.push_back({32'd100, 32'd3});
        push_exp(1'b0, 32'd298);
        pulse_start(8'h81, put2(0, 32'd2, 7, 32'd100), put2(0, 32'hFFFF_FFFF, 7, 32'd3));
        wait_resp("after_reset", 300, -1);

        repeat (5) @(negedge ctl_clk);
        check("ops_outstanding", 32'(op_q.size()), 32'd0);
        check("responses_outstanding", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
